// File: rtl/vxe_biu_rd_arbiter.sv
// Shares one AXI4 master BIU read port among NCLIENTS single-beat requesters: request FIFO toward the BIU, response FIFO back.
// Define VXE_BIU_RDARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module vxe_biu_rd_arbiter #(
    parameter int NCLIENTS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CID_WIDTH  = 8,
    parameter int RQ_DEPTH   = 4,
    parameter int RS_DEPTH   = 4
) (
    input  logic                           M_AXI4_ACLK,
    input  logic                           M_AXI4_ARESETn,
    input  logic [NCLIENTS-1:0]            cl_arvalid,
    input  logic [NCLIENTS*ADDR_WIDTH-1:0] cl_araddr,
    output logic [NCLIENTS-1:0]            cl_arready,
    output logic [NCLIENTS-1:0]            cl_rvalid,
    output logic [DATA_WIDTH-1:0]          cl_rdata,
    output logic [1:0]                     cl_rresp,
    input  logic [NCLIENTS-1:0]            cl_rready,
    output logic [CID_WIDTH-1:0]           biu_arcid,
    output logic [ADDR_WIDTH-1:0]          biu_araddr,
    output logic                           biu_arvalid,
    input  logic                           biu_arpop,
    input  logic [CID_WIDTH-1:0]           biu_rcid,
    input  logic [DATA_WIDTH-1:0]          biu_rdata,
    input  logic [1:0]                     biu_rresp,
    input  logic                           biu_rpush,
    output logic                           biu_rready,
    output logic                           arb_cid_err
);

    localparam int IDX_W = $clog2(NCLIENTS);
    localparam int RQ_PW = $clog2(RQ_DEPTH);
    localparam int RQ_CW = RQ_PW + 1;
    localparam int RS_PW = $clog2(RS_DEPTH);
    localparam int RS_CW = RS_PW + 1;

    // ---------------- arbitration ----------------
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic             rq_full;
    logic             rq_push;

`ifdef VXE_BIU_RDARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_grant_reg;
    int               cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NCLIENTS; k++) begin
            cand = int'(last_grant_reg) + 1 + k;
            if (cand >= NCLIENTS) cand = cand - NCLIENTS;
            if (!grant_any && cl_arvalid[IDX_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn)
            last_grant_reg <= '0;
        else if (rq_push)
            last_grant_reg <= grant_idx;
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NCLIENTS - 1; k >= 0; k--) begin
            if (cl_arvalid[IDX_W'(k)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
`endif

    // Grant gated by reset so no client sees a transfer while the FIFO is held empty.
    assign rq_push = grant_any && !rq_full && M_AXI4_ARESETn;

    generate
        for (genvar gi = 0; gi < NCLIENTS; gi++) begin : g_grant
            assign cl_arready[gi] = rq_push && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // ---------------- request FIFO ----------------
    logic [CID_WIDTH-1:0]  rq_cid_mem  [RQ_DEPTH];
    logic [ADDR_WIDTH-1:0] rq_addr_mem [RQ_DEPTH];
    logic [RQ_PW-1:0]      rq_wr_ptr_reg, rq_rd_ptr_reg, rq_head_ptr;
    logic [RQ_CW-1:0]      rq_count_reg;
    logic                  rq_pop;

    assign rq_full = (rq_count_reg == RQ_CW'(RQ_DEPTH));
    assign rq_pop  = biu_arpop && (rq_count_reg != '0);

    // The BIU pops the entry it latched last cycle, so during a pop it already sees the next one.
    always_comb begin
        if (biu_arpop) begin
            biu_arvalid = (rq_count_reg >= RQ_CW'(2));
            rq_head_ptr = rq_rd_ptr_reg + RQ_PW'(1);
        end else begin
            biu_arvalid = (rq_count_reg != '0);
            rq_head_ptr = rq_rd_ptr_reg;
        end
    end

    assign biu_arcid  = rq_cid_mem[rq_head_ptr];
    assign biu_araddr = rq_addr_mem[rq_head_ptr];

    always_ff @(posedge M_AXI4_ACLK) begin
        if (rq_push) begin
            rq_cid_mem[rq_wr_ptr_reg]  <= CID_WIDTH'(grant_idx);
            rq_addr_mem[rq_wr_ptr_reg] <= cl_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            rq_wr_ptr_reg <= '0;
            rq_rd_ptr_reg <= '0;
            rq_count_reg  <= '0;
        end else begin
            if (rq_push) rq_wr_ptr_reg <= rq_wr_ptr_reg + RQ_PW'(1);
            if (rq_pop)  rq_rd_ptr_reg <= rq_rd_ptr_reg + RQ_PW'(1);
            if (rq_push && !rq_pop)
                rq_count_reg <= rq_count_reg + RQ_CW'(1);
            else if (!rq_push && rq_pop)
                rq_count_reg <= rq_count_reg - RQ_CW'(1);
        end
    end

    // ---------------- response FIFO ----------------
    logic [CID_WIDTH-1:0]  rs_cid_mem  [RS_DEPTH];
    logic [DATA_WIDTH-1:0] rs_data_mem [RS_DEPTH];
    logic [1:0]            rs_resp_mem [RS_DEPTH];
    logic [RS_PW-1:0]      rs_wr_ptr_reg, rs_rd_ptr_reg;
    logic [RS_CW-1:0]      rs_count_reg;
    logic [CID_WIDTH-1:0]  rs_head_cid;
    logic                  rs_empty, rs_cid_ok, rs_pop;
    logic                  arb_cid_err_reg;

    assign rs_empty    = (rs_count_reg == '0);
    assign rs_head_cid = rs_cid_mem[rs_rd_ptr_reg];
    assign rs_cid_ok   = (rs_head_cid < CID_WIDTH'(NCLIENTS));
    assign cl_rdata    = rs_data_mem[rs_rd_ptr_reg];
    assign cl_rresp    = rs_resp_mem[rs_rd_ptr_reg];
    // Two free slots: the BIU may push one cycle after it last saw ready.
    assign biu_rready  = ((RS_CW'(RS_DEPTH) - rs_count_reg) >= RS_CW'(2));
    assign arb_cid_err = arb_cid_err_reg;

    generate
        for (genvar gi = 0; gi < NCLIENTS; gi++) begin : g_rvalid
            assign cl_rvalid[gi] = !rs_empty && (rs_head_cid == CID_WIDTH'(gi));
        end
    endgenerate

    // An out-of-range head is discarded unconditionally so it cannot block later responses.
    assign rs_pop = !rs_empty && (rs_cid_ok ? |(cl_rvalid & cl_rready) : 1'b1);

    always_ff @(posedge M_AXI4_ACLK) begin
        if (biu_rpush) begin
            rs_cid_mem[rs_wr_ptr_reg]  <= biu_rcid;
            rs_data_mem[rs_wr_ptr_reg] <= biu_rdata;
            rs_resp_mem[rs_wr_ptr_reg] <= biu_rresp;
        end
    end

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            rs_wr_ptr_reg   <= '0;
            rs_rd_ptr_reg   <= '0;
            rs_count_reg    <= '0;
            arb_cid_err_reg <= 1'b0;
        end else begin
            if (biu_rpush) rs_wr_ptr_reg <= rs_wr_ptr_reg + RS_PW'(1);
            if (rs_pop)    rs_rd_ptr_reg <= rs_rd_ptr_reg + RS_PW'(1);
            if (biu_rpush && !rs_pop)
                rs_count_reg <= rs_count_reg + RS_CW'(1);
            else if (!biu_rpush && rs_pop)
                rs_count_reg <= rs_count_reg - RS_CW'(1);
            if (!rs_empty && !rs_cid_ok)
                arb_cid_err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vxe_biu_rd_arbiter.sv
// Scoreboard bench for vxe_biu_rd_arbiter: directed stimulus pushes expected BIU requests and client responses; monitors pop and compare.
module tb_vxe_biu_rd_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int RQD = 4;
    localparam int RSD = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    cl_arvalid;
    logic [N*AW-1:0] cl_araddr;
    logic [N-1:0]    cl_arready;
    logic [N-1:0]    cl_rvalid;
    logic [DW-1:0]   cl_rdata;
    logic [1:0]      cl_rresp;
    logic [N-1:0]    cl_rready;
    logic [CW-1:0]   biu_arcid;
    logic [AW-1:0]   biu_araddr;
    logic            biu_arvalid;
    logic            biu_arpop = 1'b0;
    logic [CW-1:0]   biu_rcid;
    logic [DW-1:0]   biu_rdata;
    logic [1:0]      biu_rresp;
    logic            biu_rpush;
    logic            biu_rready;
    logic            arb_cid_err;

    always #5 clk = ~clk;

    vxe_biu_rd_arbiter #(
        .NCLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CID_WIDTH(CW), .RQ_DEPTH(RQD), .RS_DEPTH(RSD)
    ) dut (
        .M_AXI4_ACLK(clk), .M_AXI4_ARESETn(rst_n),
        .cl_arvalid(cl_arvalid), .cl_araddr(cl_araddr), .cl_arready(cl_arready),
        .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata), .cl_rresp(cl_rresp), .cl_rready(cl_rready),
        .biu_arcid(biu_arcid), .biu_araddr(biu_araddr), .biu_arvalid(biu_arvalid), .biu_arpop(biu_arpop),
        .biu_rcid(biu_rcid), .biu_rdata(biu_rdata), .biu_rresp(biu_rresp), .biu_rpush(biu_rpush),
        .biu_rready(biu_rready), .arb_cid_err(arb_cid_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [CW+AW-1:0] exp_req [$];   // {cid, addr}
    logic [CW+DW+1:0] exp_rsp [$];   // {client, data, resp}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("[%0t] ok   %s = %0h", $time, name, act);
        end else begin
            $display("[%0t] FAIL %s: got %0h, required %0h", $time, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // BIU model: latches the presented head, pops it the following cycle.
    logic biu_en  = 1'b0;
    logic latched = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            latched = 1'b0;
        end else if (biu_en && biu_arvalid) begin
            if (exp_req.size() == 0) begin
                n_checks++;
                $display("[%0t] FAIL req_unexpected: got cid %0d addr %0h, required no request",
                         $time, biu_arcid, biu_araddr);
            end else begin
                check("req_issue", 64'({biu_arcid, biu_araddr}), 64'(exp_req.pop_front()));
            end
            latched = 1'b1;
        end else begin
            latched = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        biu_arpop = latched;
    end

    // Client-side response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (cl_rvalid[i] && cl_rready[i]) begin
                    if (exp_rsp.size() == 0) begin
                        n_checks++;
                        $display("[%0t] FAIL rsp_unexpected: got client %0d data %0h, required no response",
                                 $time, i, cl_rdata);
                    end else begin
                        check("rsp_deliver", 64'({CW'(i), cl_rdata, cl_rresp}), 64'(exp_rsp.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    logic [N-1:0] exp_grant [4];

    initial begin
`ifdef VXE_BIU_RDARB_ROUND_ROBIN_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
        rst_n      = 1'b0;
        cl_arvalid = 2'b11;
        cl_araddr  = '0;
        cl_rready  = '0;
        biu_rcid   = '0;
        biu_rdata  = '0;
        biu_rresp  = '0;
        biu_rpush  = 1'b0;

        // Reset state: grants suppressed even with requests pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arready",  64'(cl_arready),  64'(0));
        check("rst_rvalid",   64'(cl_rvalid),   64'(0));
        check("rst_arvalid",  64'(biu_arvalid), 64'(0));
        check("rst_rready",   64'(biu_rready),  64'(1));
        check("rst_cid_err",  64'(arb_cid_err), 64'(0));
        step();
        rst_n      = 1'b1;
        cl_arvalid = '0;
        biu_en     = 1'b1;

        // Single request from client 1.
        step();
        cl_arvalid = 2'b10;
        cl_araddr[AW +: AW] = 32'h0000_1000;
        @(negedge clk);
        check("t1_grant", 64'(cl_arready), 64'(2'b10));
        exp_req.push_back({8'd1, 32'h0000_1000});
        step();
        cl_arvalid = '0;
        @(negedge clk);
        check("t1_arvalid", 64'(biu_arvalid), 64'(1));
        check("t1_arcid",   64'(biu_arcid),   64'(1));
        check("t1_araddr",  64'(biu_araddr),  64'(32'h1000));
        repeat (2) step();
        cl_rready = 2'b11;
        biu_rpush = 1'b1; biu_rcid = 8'd1; biu_rdata = 32'hDEAD_BEEF; biu_rresp = 2'd0;
        exp_rsp.push_back({8'd1, 32'hDEAD_BEEF, 2'd0});
        step();
        biu_rpush = 1'b0;
        @(negedge clk);
        check("t1_rvalid", 64'(cl_rvalid), 64'(2'b10));
        check("t1_rdata",  64'(cl_rdata),  64'(32'hDEAD_BEEF));

        // Contention: both clients requesting every cycle.
        step();
        cl_araddr  = {32'h0000_B000, 32'h0000_A000};
        cl_arvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_grant", 64'(cl_arready), 64'(exp_grant[k]));
            exp_req.push_back(exp_grant[k][1] ? {8'd1, 32'h0000_B000} : {8'd0, 32'h0000_A000});
            step();
        end
        cl_arvalid = '0;
        repeat (8) step();
        check("t2_drained", 64'(exp_req.size()), 64'(0));

        // Request FIFO full with the BIU stalled; one pop frees a slot only afterwards.
        biu_en     = 1'b0;
        cl_arvalid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            cl_araddr[0 +: AW] = 32'h0000_C000 + 32'(16 * k);
            @(negedge clk);
            check("t3_fill_grant", 64'(cl_arready), 64'(2'b01));
            exp_req.push_back({8'd0, 32'h0000_C000 + 32'(16 * k)});
            step();
        end
        cl_araddr[0 +: AW] = 32'h0000_C040;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t3_full", 64'(cl_arready), 64'(0));
            step();
        end
        biu_en = 1'b1;
        @(negedge clk);
        check("t3_full_latch", 64'(cl_arready), 64'(0));
        step();
        biu_en = 1'b0;
        @(negedge clk);
        check("t3_pop_no_free", 64'(cl_arready), 64'(0));
        step();
        @(negedge clk);
        check("t3_regrant", 64'(cl_arready), 64'(2'b01));
        exp_req.push_back({8'd0, 32'h0000_C040});
        step();
        @(negedge clk);
        check("t3_full_again", 64'(cl_arready), 64'(0));
        step();
        cl_arvalid = '0;
        biu_en     = 1'b1;
        repeat (8) step();
        check("t3_b2b_drained", 64'(exp_req.size()), 64'(0));

        // Response backpressure: 4 pushes, clients not ready.
        cl_rready = '0;
        for (int k = 0; k < 4; k++) begin
            biu_rpush = 1'b1;
            biu_rcid  = CW'(k % 2);
            biu_rdata = 32'h0000_5500 + 32'(k);
            biu_rresp = 2'(k);
            exp_rsp.push_back({CW'(k % 2), 32'h0000_5500 + 32'(k), 2'(k)});
            @(negedge clk);
            check("t5_rready", 64'(biu_rready), 64'(k < 3 ? 1 : 0));
            step();
        end
        biu_rpush = 1'b0;
        @(negedge clk);
        check("t5_full_rready", 64'(biu_rready), 64'(0));
        check("t5_head_wait",   64'(cl_rvalid),  64'(2'b01));
        step();
        cl_rready = 2'b11;
        repeat (6) step();
        check("t5_drained", 64'(exp_rsp.size()), 64'(0));

        // Bad client ID is discarded and latches the error flag.
        biu_rpush = 1'b1; biu_rcid = 8'd5; biu_rdata = 32'h0000_0BAD; biu_rresp = 2'd2;
        @(negedge clk);
        check("t6_err_before", 64'(arb_cid_err), 64'(0));
        step();
        biu_rpush = 1'b1; biu_rcid = 8'd0; biu_rdata = 32'h0000_600D; biu_rresp = 2'd1;
        exp_rsp.push_back({8'd0, 32'h0000_600D, 2'd1});
        @(negedge clk);
        check("t6_bad_no_rvalid", 64'(cl_rvalid), 64'(0));
        step();
        biu_rpush = 1'b0;
        @(negedge clk);
        check("t6_err_set", 64'(arb_cid_err), 64'(1));
        repeat (3) step();
        @(negedge clk);
        check("t6_err_sticky", 64'(arb_cid_err), 64'(1));
        check("t6_drained",    64'(exp_rsp.size()), 64'(0));

        // Reset mid-operation drops a queued request and response.
        step();
        biu_en     = 1'b0;
        cl_rready  = '0;
        cl_arvalid = 2'b10;
        cl_araddr[AW +: AW] = 32'h0000_E000;
        @(negedge clk);
        check("t7_grant", 64'(cl_arready), 64'(2'b10));
        step();
        cl_arvalid = '0;
        biu_rpush = 1'b1; biu_rcid = 8'd1; biu_rdata = 32'h0000_7777; biu_rresp = 2'd0;
        @(negedge clk);
        check("t7_arvalid", 64'(biu_arvalid), 64'(1));
        step();
        biu_rpush  = 1'b0;
        rst_n      = 1'b0;
        cl_arvalid = 2'b01;
        @(negedge clk);
        check("t7_rst_arready", 64'(cl_arready),  64'(0));
        check("t7_rst_arvalid", 64'(biu_arvalid), 64'(0));
        check("t7_rst_rvalid",  64'(cl_rvalid),   64'(0));
        check("t7_rst_rready",  64'(biu_rready),  64'(1));
        check("t7_rst_err",     64'(arb_cid_err), 64'(0));
        step();
        rst_n      = 1'b1;
        cl_arvalid = '0;
        cl_rready  = 2'b11;
        biu_en     = 1'b1;
        @(negedge clk);
        check("t7_post_arvalid", 64'(biu_arvalid), 64'(0));
        check("t7_post_rvalid",  64'(cl_rvalid),   64'(0));
        repeat (3) step();
        check("end_req_empty", 64'(exp_req.size()), 64'(0));
        check("end_rsp_empty", 64'(exp_rsp.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vxe_biu_rd_arbiter.md
# vxe_biu_rd_arbiter

Read-path arbiter that shares one AXI4 master BIU read interface among NCLIENTS requesters. It accepts single-beat read requests from the clients, queues them in a request FIFO toward the BIU, and routes BIU read responses back to the issuing client through a response FIFO. The client index is used as the BIU client ID. It sits between the engine's memory clients and the AXI4 master BIU.

## Interface
- NCLIENTS, 2: number of requesters, 2..8.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- CID_WIDTH, 8: BIU client ID width, ≥ clog2(NCLIENTS).
- RQ_DEPTH, 4: request FIFO depth, power of 2, ≥2.
- RS_DEPTH, 4: response FIFO depth, power of 2, ≥2.

Ports:
- M_AXI4_ACLK  in  1  clock.
- M_AXI4_ARESETn  in  1  reset, asynchronous, active-low.
- cl_arvalid  in  NCLIENTS  per-client request valid.
- cl_araddr  in  NCLIENTS*ADDR_WIDTH  per-client address; client i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- cl_arready  out  NCLIENTS  one-hot grant; a request transfers when cl_arvalid[i] and cl_arready[i] are both high.
- cl_rvalid  out  NCLIENTS  one-hot response valid.
- cl_rdata  out  DATA_WIDTH  response data, shared by all clients.
- cl_rresp  out  2  response code, shared by all clients.
- cl_rready  in  NCLIENTS  per-client response ready.
- biu_arcid  out  CID_WIDTH  request client ID.
- biu_araddr  out  ADDR_WIDTH  request address.
- biu_arvalid  out  1  request available.
- biu_arpop  in  1  BIU consumed the request presented in the previous cycle.
- biu_rcid  in  CID_WIDTH  response client ID.
- biu_rdata  in  DATA_WIDTH  response data.
- biu_rresp  in  2  response code.
- biu_rpush  in  1  response write.
- biu_rready  out  1  the BIU may accept an AXI R beat.
- arb_cid_err  out  1  sticky flag: a response arrived with a client ID ≥ NCLIENTS.

## Operation
- Request FIFO entry is {cid, addr}, with cid = the granted client index, zero-extended to CID_WIDTH.
- Grant:
  - At most one client per cycle, and only when the request FIFO is not full.
  - A pop in the same cycle does not free a slot; this is the conservative rule.
  - cl_arready is combinational from cl_arvalid, the FIFO-full flag and the arbitration state.
- BIU issue, look-ahead head:
  - The BIU latches the head in cycle t and asserts biu_arpop in cycle t+1.
  - While biu_arpop=1, biu_arvalid/arcid/araddr present entry rd_ptr+1, and biu_arvalid = (count ≥ 2).
  - Otherwise biu_arvalid = (count ≠ 0) and the outputs present rd_ptr.
  - This rule prevents double issue and allows back-to-back issue.
- Response capture:
  - biu_rpush writes {rcid, rdata, rresp} into the response FIFO.
  - biu_rready = (free entries ≥ 2); this covers the one-cycle push lag. A push into a full FIFO never occurs.
- Response dispatch:
  - Let h be the head cid.
  - If h < NCLIENTS: cl_rvalid[h] = !empty. The head pops when cl_rready[h] is high.
  - If h ≥ NCLIENTS: the head is discarded in one cycle with no cl_rvalid, and arb_cid_err sets. Only reset clears it.
- Responses are delivered strictly in BIU push order, with no per-client reordering.

## Timing
- Reset values: FIFOs empty, pointers 0, arbitration pointer 0, arb_cid_err 0.
  - While reset is asserted: cl_arready=0, cl_rvalid=0, biu_arvalid=0, biu_rready=1.
  - Reset mid-operation drops every queued request and response.
- Request latency: grant in cycle t → biu_arvalid high in t+1 (FIFO was empty).
- Response latency: biu_rpush in t → cl_rvalid high in t+1 (FIFO was empty).
- Throughput: one grant per cycle while the FIFO is not full. One response delivered per cycle while the target is ready.
- Simultaneous push and pop on either FIFO: both happen and count is unchanged. Pointers wrap modulo depth.

## Configuration
- VXE_BIU_RDARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration.
  - Search starts at last_grant+1 and wraps modulo NCLIENTS; last_grant updates on each transfer.
- Not defined:
  - Fixed priority; the lowest active index wins.
  - The arbitration pointer register is removed.

## Test plan
- Single request: client 1 reads 0x1000, BIU pops, rpush with rcid=1, rdata=0xDEADBEEF, rresp=0 → biu_arcid=1 one cycle after the grant; cl_rvalid=2'b10 with data 0xDEADBEEF one cycle after the push.
- Contention, both clients requesting continuously, ROUND_ROBIN_EN on → grants alternate 0,1,0,1. With the macro off → client 0 receives every grant.
- Request FIFO full: RQ_DEPTH=4, no biu_arpop → 4 grants, then cl_arready=0. After one pop, the next grant occurs only in the cycle after the pop.
- Back-to-back issue: pops on consecutive entries A, B → while biu_arpop=1, biu_araddr shows B. Each address is issued exactly once.
- Response backpressure: cl_rready=0, RS_DEPTH=4 → biu_rready drops when 3 entries are held. The FIFO never overflows, and all 4 responses are delivered in push order after ready rises.
- Bad ID: rpush with rcid=5, NCLIENTS=2 → no cl_rvalid, entry dropped, arb_cid_err=1 until reset.
